tl_control_responder: RTL and testbench
=======================================

// Module: tl_control_responder
// PURPOSE
//  TileLink-UL responder terminating the control-crossing port: accepts A-channel requests
//  (Get/PutFullData/PutPartialData) from the upstream fragmenter, which has already split them
//  into single 8-byte beats. Returns one D-channel response per request.
//  Holds a bank of 64-bit control registers, also exported flat to local logic.
//  Single outstanding response; one-entry D output buffer.
// PARAMETERS
//  NREGS      8           number of 64-bit registers (power of 2, 2..64)
//  BASE_ADDR  31'h0C00_0000  base of register window (aligned to NREGS*8)
//  SRC_W      7           A/D source width
// PORTS
//  clock                  in   1        sole clock
//  reset                  in   1        synchronous, active-high
//  auto_in_a_ready        out  1        request accepted this cycle when a_valid & a_ready
//  auto_in_a_valid        in   1
//  auto_in_a_bits_opcode  in   3        0 PutFull, 1 PutPartial, 4 Get; others unsupported
//  auto_in_a_bits_param   in   3        ignored
//  auto_in_a_bits_size    in   2        log2 bytes, 0..3
//  auto_in_a_bits_source  in   SRC_W
//  auto_in_a_bits_address in   31
//  auto_in_a_bits_mask    in   8        byte-lane enables
//  auto_in_a_bits_data    in   64
//  auto_in_a_bits_corrupt in   1        corrupt write data: write suppressed, still acked
//  auto_in_d_ready        in   1
//  auto_in_d_valid        out  1
//  auto_in_d_bits_opcode  out  3        0 AccessAck, 1 AccessAckData
//  auto_in_d_bits_size    out  2        echo of a_size
//  auto_in_d_bits_source  out  SRC_W    echo of a_source
//  auto_in_d_bits_data    out  64       read data, full word on all lanes; 0 for acks
//  auto_in_d_bits_denied  out  1        only with TL_CTRL_RESP_ERR_EN
//  ctrl_regs              out  NREGS*64 register contents, reg i at [64*i+:64]
// BEHAVIOUR
//  - Reset (sync): d_valid=0, d_opcode/size/source/data=0, all registers=0, denied=0.
//  - a_ready = !d_valid | d_ready (combinational; accepts while buffer drains same cycle).
//  - Hit: address[30:3] - BASE_ADDR[30:3] < NREGS; index = that difference.
//  - On accept: register the response, d_valid=1 next cycle (latency 1). d_valid holds,
//    d_bits stable, until d_ready; back-to-back accepts give one response per cycle.
//  - Get: AccessAckData, data = register[index] sampled at accept (before any same-edge write);
//    miss returns 64'h0.
//  - PutFull/PutPartial hit with !corrupt: byte i written iff mask[i]; new value visible on
//    ctrl_regs and to Gets accepted from the next cycle. Response AccessAck, data 0.
//  - Put miss or corrupt: no write, AccessAck.
//  - Unsupported opcode (2,3,5,6,7): no state change, AccessAck.
//  - Reset asserted with d_valid=1: pending response dropped, registers cleared.
//  - No ordering hazard: one request in flight; response buffer is the only state besides regs.
// CONFIGURATION
//  TL_CTRL_RESP_ERR_EN defined: auto_in_d_bits_denied port present; denied=1 for miss,
//    unsupported opcode, or corrupt Put (Get miss: AccessAckData, data 0, denied=1);
//    registered with the response.
//  Undefined: port absent; all errors silently acked as above.
// STRUCTURE
//  Package tl_ctrl_pkg: TL opcode localparams (PUT_FULL, PUT_PARTIAL, GET, ACCESS_ACK,
//    ACCESS_ACK_DATA), resp_t struct {opcode,size,source,data,denied}.
//  Sub-module tl_ctrl_regfile: NREGS x 64 flops, masked byte write port, async read port,
//    flat output. Top holds decode, a_ready logic and the one-entry response buffer.
// TESTING
//  1 Reset, then PutFull addr=BASE+0x10 mask=FF data=0x1122334455667788 src=5 -> next cycle
//    d_valid, opcode 0, source 5, size 3; ctrl_regs[191:128]=0x1122334455667788.
//  2 PutPartial addr=BASE+0x10 mask=0x0F data=0xAAAAAAAA_BBBBBBBB, then Get same addr src=9 ->
//    AccessAckData source 9 data 0x11223344_BBBBBBBB.
//  3 Hold d_ready=0 four cycles with second request pending -> a_ready=0, d_bits stable;
//    d_ready=1 -> a_ready=1 same cycle, second response next cycle, no loss.
//  4 Get addr=BASE+NREGS*8 -> data 0, opcode 1; with ERR_EN denied=1, without no denied port.
//  5 Stream 16 Gets with d_ready=1 -> 16 consecutive d_valid beats, sources echoed in order.
//  6 Assert reset while d_valid=1 -> d_valid=0 next cycle, all ctrl_regs=0.

Source files
------------

// File: rtl/tl_ctrl_pkg.sv
// tl_ctrl_pkg: TileLink-UL opcodes and the registered D-channel response record.
package tl_ctrl_pkg;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;
  localparam int SRC_MAX_W = 16;
  typedef struct packed {
    logic [2:0]           opcode;
    logic [1:0]           size;
    logic [SRC_MAX_W-1:0] source;
    logic [63:0]          data;
    logic                 denied;
  } resp_t;
endpackage

// File: rtl/tl_ctrl_regfile.sv
// tl_ctrl_regfile: NREGS x 64-bit registers with byte-masked write, async read, flat export.
module tl_ctrl_regfile #(
  parameter int NREGS = 8,
  parameter int IW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [7:0]        i_wmask,
  input  logic [63:0]       i_wdata,
  input  logic [IW-1:0]     i_ridx,
  output logic [63:0]       o_rdata,
  output logic [NREGS*64-1:0] o_regs
);
  logic [63:0] r_regs [NREGS];
  always_ff @(posedge clk) begin
    if (rst) r_regs <= '{default: '0};
    else if (i_we)
      for (int b = 0; b < 8; b++)
        if (i_wmask[b]) r_regs[i_widx][8*b+:8] <= i_wdata[8*b+:8];
  end
  assign o_rdata = r_regs[i_ridx];
  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign o_regs[64*i+:64] = r_regs[i];
  end
endmodule

// File: rtl/tl_control_responder.sv
// tl_control_responder: TileLink-UL register responder with a one-entry D buffer.
// Define TL_CTRL_RESP_ERR_EN to add auto_in_d_bits_denied for misses, bad opcodes and corrupt Puts.
module tl_control_responder
  import tl_ctrl_pkg::*;
#(
  parameter int          NREGS     = 8,
  parameter logic [30:0] BASE_ADDR = 31'h0C00_0000,
  parameter int          SRC_W     = 7
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [1:0]        auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [30:0]       auto_in_a_bits_address,
  input  logic [7:0]        auto_in_a_bits_mask,
  input  logic [63:0]       auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic [63:0]       auto_in_d_bits_data,
`ifdef TL_CTRL_RESP_ERR_EN
  output logic              auto_in_d_bits_denied,
`endif
  output logic [NREGS*64-1:0] ctrl_regs
);
  localparam int IW = $clog2(NREGS);
  logic [27:0]   w_off;
  logic          w_hit, w_get, w_put, w_accept, w_we, w_err, w_unused;
  logic [IW-1:0] w_idx;
  logic [63:0]   w_rdata;
  resp_t         w_resp, r_resp;
  logic          r_valid;
  assign w_off    = auto_in_a_bits_address[30:3] - BASE_ADDR[30:3];
  assign w_hit    = w_off < 28'(NREGS);
  assign w_idx    = w_off[IW-1:0];
  assign w_get    = auto_in_a_bits_opcode == GET;
  assign w_put    = auto_in_a_bits_opcode == PUT_FULL || auto_in_a_bits_opcode == PUT_PARTIAL;
  assign auto_in_a_ready = !r_valid || auto_in_d_ready;
  assign w_accept = auto_in_a_valid && auto_in_a_ready;
  assign w_we     = w_accept && w_put && w_hit && !auto_in_a_bits_corrupt;
  assign w_unused = ^{auto_in_a_bits_param, auto_in_a_bits_address[2:0]};
`ifdef TL_CTRL_RESP_ERR_EN
  assign w_err = !w_hit || !(w_get || w_put) || (w_put && auto_in_a_bits_corrupt);
  assign auto_in_d_bits_denied = r_resp.denied;
`else
  assign w_err = 1'b0;
`endif
  // Read data is sampled before the write of the same edge lands in the regfile.
  assign w_resp = '{
    opcode: w_get ? ACCESS_ACK_DATA : ACCESS_ACK,
    size:   auto_in_a_bits_size,
    source: SRC_MAX_W'(auto_in_a_bits_source),
    data:   (w_get && w_hit) ? w_rdata : 64'h0,
    denied: w_err
  };
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_resp  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_resp  <= w_resp;
    end else if (auto_in_d_ready) r_valid <= 1'b0;
  end
  assign auto_in_d_valid       = r_valid;
  assign auto_in_d_bits_opcode = r_resp.opcode;
  assign auto_in_d_bits_size   = r_resp.size;
  assign auto_in_d_bits_source = r_resp.source[SRC_W-1:0];
  assign auto_in_d_bits_data   = r_resp.data;
  tl_ctrl_regfile #(.NREGS(NREGS)) u_regs (
    .clk     (clock),
    .rst     (reset),
    .i_we    (w_we),
    .i_widx  (w_idx),
    .i_wmask (auto_in_a_bits_mask),
    .i_wdata (auto_in_a_bits_data),
    .i_ridx  (w_idx),
    .o_rdata (w_rdata),
    .o_regs  (ctrl_regs)
  );
endmodule

// File: tb/tb_tl_control_responder.sv
// tb_tl_control_responder: directed vectors against hand-computed TileLink responses.
module tb_tl_control_responder;
  localparam logic [30:0] BASE = 31'h0C00_0000;
  logic clock = 0, reset = 1;
  logic a_ready, a_valid = 0, a_corrupt = 0, d_ready = 1, d_valid;
  logic [2:0] a_opcode = 0, a_param = 0, d_opcode;
  logic [1:0] a_size = 3, d_size;
  logic [6:0] a_source = 0, d_source;
  logic [30:0] a_address = 0;
  logic [7:0] a_mask = 0;
  logic [63:0] a_data = 0, d_data;
  logic [511:0] ctrl_regs;
`ifdef TL_CTRL_RESP_ERR_EN
  logic d_denied;
`endif
  logic [63:0] exp_regs [8];
  int checks = 0, failures = 0;
  always #5 clock = ~clock;
  tl_control_responder dut (
    .clock(clock), .reset(reset),
    .auto_in_a_ready(a_ready), .auto_in_a_valid(a_valid),
    .auto_in_a_bits_opcode(a_opcode), .auto_in_a_bits_param(a_param),
    .auto_in_a_bits_size(a_size), .auto_in_a_bits_source(a_source),
    .auto_in_a_bits_address(a_address), .auto_in_a_bits_mask(a_mask),
    .auto_in_a_bits_data(a_data), .auto_in_a_bits_corrupt(a_corrupt),
    .auto_in_d_ready(d_ready), .auto_in_d_valid(d_valid),
    .auto_in_d_bits_opcode(d_opcode), .auto_in_d_bits_size(d_size),
    .auto_in_d_bits_source(d_source), .auto_in_d_bits_data(d_data),
`ifdef TL_CTRL_RESP_ERR_EN
    .auto_in_d_bits_denied(d_denied),
`endif
    .ctrl_regs(ctrl_regs)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic req(input logic [2:0] op, input logic [30:0] addr, input logic [7:0] mask,
                     input logic [63:0] data, input logic [6:0] src, input logic corrupt);
    @(negedge clock);
    a_valid = 1; a_opcode = op; a_address = addr; a_mask = mask;
    a_data = data; a_source = src; a_corrupt = corrupt; a_size = 3;
    #1 check("a_ready", 64'(a_ready), 1);
    @(posedge clock);
    #1 a_valid = 0; a_corrupt = 0;
  endtask
  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) check(tag, ctrl_regs[64*i+:64], exp_regs[i]);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) exp_regs[i] = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    check("rst_dvalid", 64'(d_valid), 0);
    check("rst_ddata", d_data, 0);
    check_regs("rst_regs");
    // PutFull then PutPartial to register 2
    req(3'd0, BASE + 31'h10, 8'hFF, 64'h1122334455667788, 7'd5, 0);
    exp_regs[2] = 64'h1122334455667788;
    check("pf_dvalid", 64'(d_valid), 1);
    check("pf_opcode", 64'(d_opcode), 0);
    check("pf_source", 64'(d_source), 5);
    check("pf_size", 64'(d_size), 3);
    check("pf_data", d_data, 0);
    check("pf_reg2", ctrl_regs[191:128], exp_regs[2]);
    req(3'd1, BASE + 31'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 7'd6, 0);
    exp_regs[2] = 64'h11223344_BBBBBBBB;
    req(3'd4, BASE + 31'h10, 8'hFF, 0, 7'd9, 0);
    check("get_opcode", 64'(d_opcode), 1);
    check("get_source", 64'(d_source), 9);
    check("get_data", d_data, exp_regs[2]);
    req(3'd1, BASE, 8'h81, 64'hAB11_2233_4455_66CD, 7'd10, 0);
    exp_regs[0] = 64'hAB00_0000_0000_00CD;
    req(3'd0, BASE + 31'h38, 8'hFF, 64'hDEADBEEF_CAFEF00D, 7'd11, 0);
    exp_regs[7] = 64'hDEADBEEF_CAFEF00D;
    // Writes that must not land: miss below, miss above, corrupt, unsupported opcode
    req(3'd0, BASE - 31'h8, 8'hFF, 64'h1, 7'd12, 0);
    req(3'd0, BASE + 31'h40, 8'hFF, 64'h2, 7'd13, 0);
    req(3'd0, BASE + 31'h18, 8'hFF, 64'h3, 7'd14, 1);
    check("corrupt_ack", 64'(d_opcode), 0);
`ifdef TL_CTRL_RESP_ERR_EN
    check("corrupt_denied", 64'(d_denied), 1);
`endif
    req(3'd2, BASE + 31'h18, 8'hFF, 64'h4, 7'd15, 0);
    check("unsup_opcode", 64'(d_opcode), 0);
    check("unsup_source", 64'(d_source), 15);
    check_regs("nowrite_regs");
    // Backpressure: hold the second request while the first response stalls
    @(posedge clock);
    #1 d_ready = 0;
    req(3'd4, BASE + 31'h10, 8'hFF, 0, 7'd1, 0);
    @(negedge clock);
    a_valid = 1; a_opcode = 3'd4; a_address = BASE; a_source = 7'd2;
    repeat (4) begin
      #1 check("bp_aready", 64'(a_ready), 0);
      check("bp_source", 64'(d_source), 1);
      check("bp_data", d_data, exp_regs[2]);
      @(negedge clock);
    end
    d_ready = 1;
    #1 check("bp_release", 64'(a_ready), 1);
    @(posedge clock);
    #1 a_valid = 0;
    check("bp2_dvalid", 64'(d_valid), 1);
    check("bp2_source", 64'(d_source), 2);
    check("bp2_data", d_data, exp_regs[0]);
    // Get one past the top of the window
    req(3'd4, BASE + 31'h40, 8'hFF, 0, 7'd20, 0);
    check("miss_opcode", 64'(d_opcode), 1);
    check("miss_data", d_data, 0);
`ifdef TL_CTRL_RESP_ERR_EN
    check("miss_denied", 64'(d_denied), 1);
`endif
    // Back-to-back stream of Gets
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      a_valid = 1; a_opcode = 3'd4; a_address = BASE + 31'(8 * (k % 8)); a_source = 7'(16 + k);
      @(posedge clock);
      #1 check("stream_dvalid", 64'(d_valid), 1);
      check("stream_source", 64'(d_source), 64'(16 + k));
      check("stream_data", d_data, exp_regs[k % 8]);
    end
    a_valid = 0;
    @(posedge clock);
    #1 check("stream_drain", 64'(d_valid), 0);
    // Reset with a pending response
    d_ready = 0;
    req(3'd4, BASE + 31'h38, 8'hFF, 0, 7'd3, 0);
    check("pre_rst_dvalid", 64'(d_valid), 1);
    @(negedge clock);
    reset = 1;
    @(posedge clock);
    #1 reset = 0; d_ready = 1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 0;
    check("post_rst_dvalid", 64'(d_valid), 0);
    check("post_rst_data", d_data, 0);
    check_regs("post_rst_regs");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
